sobel_kernel: RTL and testbench

- Combinational 3x3 Sobel edge detector for 8-bit grayscale pixels.
- Takes the eight neighbours of a centre pixel and computes the gradient magnitude as |Gx|+|Gy|. It compares that magnitude against a threshold and produces a 1-bit edge flag.
- An image-scanning controller sits upstream. It presents one window per clock and stores the flag for the centre pixel into the output image.
- A registered copy of the flag is also provided for pipelined consumers.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_grad.sv | 24 ++
 rtl/sobel_kernel.sv | 75 +++++++
 tb/tb_sobel_kernel.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the 3x3 Sobel edge detector.
// Widths cover the full dynamic range, so no stage ever saturates.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 10;
  localparam int MAG_W = 11;

  localparam logic [MAG_W-1:0] THRESHOLD_DEFAULT = 11'd128;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic        [SUM_W-1:0] sum_t;
  typedef logic signed [MAG_W-1:0] grad_t;
  typedef logic        [MAG_W-1:0] mag_t;

endpackage

// File: rtl/sobel_grad.sv
// One Sobel gradient axis: (p0 + 2*p1 + p2) - (n0 + 2*n1 + n2).
// Each weighted triple fits in 10 bits; the difference fits in 11-bit signed.
module sobel_grad
  import sobel_pkg::*;
(
  input  pix_t  p0,
  input  pix_t  p1,
  input  pix_t  p2,
  input  pix_t  n0,
  input  pix_t  n1,
  input  pix_t  n2,
  output grad_t grad
);

  sum_t sum_p;
  sum_t sum_n;

  always_comb begin
    sum_p = {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2};
    sum_n = {2'b00, n0} + {1'b0, n1, 1'b0} + {2'b00, n2};
    grad  = grad_t'({1'b0, sum_p}) - grad_t'({1'b0, sum_n});
  end

endmodule

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel magnitude |Gx|+|Gy| with threshold flag,
// plus a registered copy of the flag for pipelined consumers.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter logic [MAG_W-1:0] THRESHOLD = THRESHOLD_DEFAULT,
  parameter int               PIX_W     = sobel_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PIX_W-1:0] In0,
  input  logic [PIX_W-1:0] In1,
  input  logic [PIX_W-1:0] In2,
  input  logic [PIX_W-1:0] In3,
  input  logic [PIX_W-1:0] In4,
  input  logic [PIX_W-1:0] In5,
  input  logic [PIX_W-1:0] In6,
  input  logic [PIX_W-1:0] In7,
  output logic             result,
  output logic [MAG_W-1:0] mag,
  output logic             result_q
);

  grad_t gx;
  grad_t gy;
  mag_t  abs_x;
  mag_t  abs_y;
  logic  result_d;
  logic  result_r_q;

  // Gx: right column positive, left column negative
  sobel_grad u_grad_x (
    .p0   (In2),
    .p1   (In4),
    .p2   (In7),
    .n0   (In0),
    .n1   (In3),
    .n2   (In5),
    .grad (gx)
  );

  // Gy: bottom row positive, top row negative
  sobel_grad u_grad_y (
    .p0   (In5),
    .p1   (In6),
    .p2   (In7),
    .n0   (In0),
    .n1   (In1),
    .n2   (In2),
    .grad (gy)
  );

  // |G| never exceeds 1020, so negating the 11-bit value cannot overflow
  always_comb begin
    abs_x  = gx[MAG_W-1] ? mag_t'(-gx) : mag_t'(gx);
    abs_y  = gy[MAG_W-1] ? mag_t'(-gy) : mag_t'(gy);
    mag    = abs_x + abs_y;
    result = (mag > THRESHOLD);
  end

  always_comb begin
    result_d = result;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_r_q <= 1'b0;
    end else begin
      result_r_q <= result_d;
    end
  end

  assign result_q = result_r_q;

endmodule

// File: tb/tb_sobel_kernel.sv
// Directed and random checks of sobel_kernel against an integer Sobel model.
module tb_sobel_kernel;

  localparam int THR = 128;

  logic        clk;
  logic        rstn;
  logic [7:0]  px [8];
  logic        result;
  logic [10:0] mag;
  logic        result_q;

  int checks = 0;
  int passes = 0;
  bit chk_en = 0;
  logic exp_q;

  sobel_kernel #(.THRESHOLD(11'd128)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .In0      (px[0]),
    .In1      (px[1]),
    .In2      (px[2]),
    .In3      (px[3]),
    .In4      (px[4]),
    .In5      (px[5]),
    .In6      (px[6]),
    .In7      (px[7]),
    .result   (result),
    .mag      (mag),
    .result_q (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: window layout (r-1: 0 1 2 / r: 3 . 4 / r+1: 5 6 7)
  function automatic int model_mag();
    int gx, gy;
    gx = (int'(px[2]) + 2*int'(px[4]) + int'(px[7])) - (int'(px[0]) + 2*int'(px[3]) + int'(px[5]));
    gy = (int'(px[5]) + 2*int'(px[6]) + int'(px[7])) - (int'(px[0]) + 2*int'(px[1]) + int'(px[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return gx + gy;
  endfunction

  function automatic logic model_res();
    return model_mag() > THR;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) exp_q <= 1'b0;
    else       exp_q <= model_res();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mag", int'(mag), model_mag());
      check("cyc_result", int'(result), int'(model_res()));
      check("cyc_result_q", int'(result_q), int'(exp_q));
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic apply(input string name, input int a0, input int a1, input int a2, input int a3,
                       input int a4, input int a5, input int a6, input int a7,
                       input int em, input int er);
    #1;
    px[0] = 8'(a0); px[1] = 8'(a1); px[2] = 8'(a2); px[3] = 8'(a3);
    px[4] = 8'(a4); px[5] = 8'(a5); px[6] = 8'(a6); px[7] = 8'(a7);
    #1;
    check({name, "_model"}, model_mag(), em);
    @(negedge clk);
    check({name, "_mag"}, int'(mag), em);
    check({name, "_result"}, int'(result), er);
    @(posedge clk);
    #1;
    check({name, "_result_q"}, int'(result_q), er);
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 8; i++) px[i] = 8'd0;
    #1;
    check("reset_result_q", int'(result_q), 0);
    @(posedge clk);
    #1;
    check("reset_hold_result_q", int'(result_q), 0);
    rstn   = 1'b1;
    chk_en = 1'b1;

    apply("flat",      100,100,100,100,100,100,100,100,    0, 0);
    apply("vert_edge",   0,  0,255,  0,255,  0,  0,255, 1020, 1);
    apply("neg_grad",  255,  0,  0,255,  0,255,  0,  0, 1020, 1);
    apply("thr_eq",      0,  0,  0,  0, 64,  0,  0,  0,  128, 0);
    apply("thr_above",   0,  0,  0,  0, 65,  0,  0,  0,  130, 1);
    apply("all_white", 255,255,255,255,255,255,255,255,    0, 0);
    apply("anti_diag",   0,255,255,  0,255,  0,  0,  0, 1530, 1);
    apply("diagonal",    0,  0,  0,  0,255,  0,255,255, 1530, 1);

    // Reset between edges: result_q clears at once, comb path keeps tracking
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_result_q", int'(result_q), 0);
    check("midrst_result", int'(result), 1);
    check("midrst_mag", int'(mag), 1530);
    @(posedge clk);
    #1;
    check("midrst_hold_result_q", int'(result_q), 0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    check("midrst_released_q", int'(result_q), 0);
    @(posedge clk);
    #1;
    check("postrst_result_q", int'(result_q), 1);

    for (int k = 0; k < 40; k++) begin
      #1;
      for (int i = 0; i < 8; i++) px[i] = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
